// File: rtl/div_seq_nb.sv
// div_seq_nb: n-bit iterative restoring divider, one quotient bit per clock.
// Each iteration shifts one dividend bit into an (n+1)-bit partial
// remainder and then does a trial subtract (P' + ~{0,divisor} + 1).
// A negative trial result means the old partial remainder is kept.
// It uses a start/busy/done handshake, and its result registers hold
// their values until the next result is written.
// Optional feature: define DIV_SIGNED_EN to add the signed_op port.
// With signed_op=1 the divider takes two's complement operands. It
// divides the magnitudes and applies the signs on the final write.
module div_seq_nb #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic         signed_op,
`endif
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int cw = $clog2(n + 1);
  localparam logic [cw-1:0] cnt_n   = cw'(n);
  localparam logic [cw-1:0] cnt_one = cw'(1);
  localparam logic [n-1:0]  one_n   = n'(1);
  localparam logic [n:0]    one_n1  = (n+1)'(1);

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_calc = 2'd1,
    s_done = 2'd2
  } state_t;

  state_t        state_reg;
  logic [cw-1:0] count_reg;
  logic [n-1:0]  dvd_reg;    // dividend magnitude, shifted out MSB first
  logic [n-1:0]  dvs_reg;    // divisor magnitude
  logic [n:0]    p_reg;      // partial remainder
  logic [n-1:0]  q_reg;      // quotient bits collected so far
  logic          neg_q_reg;  // negate the quotient on the final write
  logic          neg_r_reg;  // negate the remainder on the final write

  logic          neg_a;
  logic          neg_b;
  logic [n-1:0]  mag_a;
  logic [n-1:0]  mag_b;
  logic [n:0]    p_shift;
  logic [n:0]    trial;
  logic [n:0]    p_next;
  logic          q_bit;
  logic [n-1:0]  q_final;
  logic [n-1:0]  r_final;

  // Operand magnitudes, and whether each operand counts as negative.
  always_comb begin
`ifdef DIV_SIGNED_EN
    neg_a = signed_op & dividend[n-1];
    neg_b = signed_op & divisor[n-1];
`else
    neg_a = 1'b0;
    neg_b = 1'b0;
`endif
    mag_a = neg_a ? (~dividend + one_n) : dividend;
    mag_b = neg_b ? (~divisor + one_n) : divisor;
  end

  // One restoring step: shift, trial subtract, keep or restore.
  always_comb begin
    p_shift = {p_reg[n-1:0], dvd_reg[n-1]};
    trial   = p_shift + ~{1'b0, dvs_reg} + one_n1;
    q_bit   = ~trial[n];
    p_next  = q_bit ? trial : p_shift;
    q_final = {q_reg[n-2:0], q_bit};
    r_final = p_next[n-1:0];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= s_idle;
      count_reg   <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        s_idle, s_done: begin
          if (start && (divisor != '0)) begin
            state_reg   <= s_calc;
            count_reg   <= cnt_n;
            dvd_reg     <= mag_a;
            dvs_reg     <= mag_b;
            p_reg       <= '0;
            q_reg       <= '0;
            neg_q_reg   <= neg_a ^ neg_b;
            neg_r_reg   <= neg_a;
            busy        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
          end else if (start) begin
            // A zero divisor skips the iterations. The result is ready
            // in the cycle right after start is accepted.
            state_reg   <= s_done;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state_reg <= s_idle;
            done      <= 1'b0;
          end
        end
        s_calc: begin
          // A start received here is ignored. It is not queued.
          p_reg     <= p_next;
          q_reg     <= q_final;
          dvd_reg   <= {dvd_reg[n-2:0], 1'b0};
          count_reg <= count_reg - cnt_one;
          if (count_reg == cnt_one) begin
            state_reg <= s_done;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= neg_q_reg ? (~q_final + one_n) : q_final;
            remainder <= neg_r_reg ? (~r_final + one_n) : r_final;
          end
        end
        default: begin
          state_reg <= s_idle;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
